// File: rtl/music_player_pkg.sv
// Shared definitions for the song sequencer: state encoding, duration unit,
// rest threshold and the default widths shared with the song ROM.
package music_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

    // A ROM duration of 0 is treated as this many eighth units.
    localparam int EIGHTH = 1;
    // Half-period counts at or below this value are rests.
    localparam int REST = 1;

    localparam int DEF_NUM_W  = 10;
    localparam int DEF_NOTE_W = 20;
    localparam int DEF_DUR_W  = 5;

endpackage

// File: rtl/music_player_tone_gen.sv
// Square-wave generator: toggles sq every half_period clocks, holds sq low
// for rests or while clear is asserted.
module tone_gen
    import music_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [NOTE_W-1:0] half_period,
    output logic              sq
);

    logic [NOTE_W-1:0] tone_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            sq       <= 1'b0;
        end else if (clear || (half_period <= NOTE_W'(REST))) begin
            tone_cnt <= '0;
            sq       <= 1'b0;
        end else if (tone_cnt == (half_period - NOTE_W'(1))) begin
            tone_cnt <= '0;
            sq       <= ~sq;
        end else begin
            tone_cnt <= tone_cnt + NOTE_W'(1);
        end
    end

endmodule

// File: rtl/music_player.sv
// Song sequencer: walks the song ROM entry by entry, timing each entry in
// eighth-note beats and driving the speaker through tone_gen.
module music_player
    import music_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int EIGHTH_CYCLES = CLK_HZ / 8,
    parameter int SONG_LEN      = 45,
    parameter int NUM_W         = DEF_NUM_W,
    parameter int NOTE_W        = DEF_NOTE_W,
    parameter int DUR_W         = DEF_DUR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    output logic [NUM_W-1:0]  number,
    output logic              speaker,
    output logic              busy,
    output logic              done
);

    localparam int BEAT_W = (EIGHTH_CYCLES > 1) ? $clog2(EIGHTH_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(EIGHTH_CYCLES - 1);
    localparam logic [NUM_W-1:0]  LAST_IDX  = NUM_W'(SONG_LEN - 1);

    state_t             state;
    logic [NOTE_W-1:0]  note_q;
    logic [DUR_W-1:0]   rem;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               tone_clear;

    // Silence the tone everywhere except an uninterrupted PLAY cycle.
    assign tone_clear = (state != PLAY) || stop;

    tone_gen #(.NOTE_W(NOTE_W)) u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tone_clear),
        .half_period (note_q),
        .sq          (speaker)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            number   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_q   <= '0;
            rem      <= '0;
            beat_cnt <= '0;
        end else if (stop) begin
            state    <= IDLE;
            number   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    number <= '0;
                    done   <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    note_q   <= note;
                    rem      <= (duration == '0) ? DUR_W'(EIGHTH) : duration;
                    beat_cnt <= '0;
                    state    <= PLAY;
                end
                PLAY: begin
                    if (beat_cnt == BEAT_LAST) begin
                        beat_cnt <= '0;
                        if (rem == DUR_W'(1)) begin
                            if (number < LAST_IDX) begin
                                number <= number + NUM_W'(1);
                                state  <= LOAD;
                            end else if (loop_en) begin
                                number <= '0;
                                state  <= LOAD;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            rem <= rem - DUR_W'(1);
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                DONE: begin
                    number <= '0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a three-entry stub ROM and
// eight-clock eighth notes.
module tb_music_player;
    import music_pkg::*;

    localparam int NUM_W  = 10;
    localparam int NOTE_W = 20;
    localparam int DUR_W  = 5;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic [NUM_W-1:0]  number;
    logic              speaker;
    logic              busy;
    logic              done;
    logic              dur0_mode;

    int checks = 0;
    int errors = 0;

    music_player #(
        .CLK_HZ        (64),
        .EIGHTH_CYCLES (8),
        .SONG_LEN      (3),
        .NUM_W         (NUM_W),
        .NOTE_W        (NOTE_W),
        .DUR_W         (DUR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .note     (rom_note),
        .duration (rom_dur),
        .number   (number),
        .speaker  (speaker),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub song: 0:{4,1} 1:{rest,2} 2:{2,1}; entry 0 duration can be forced to 0.
    always_comb begin
        rom_note = '0;
        rom_dur  = '0;
        case (number)
            10'd0: begin rom_note = 20'd4; rom_dur = dur0_mode ? 5'd0 : 5'd1; end
            10'd1: begin rom_note = 20'd1; rom_dur = 5'd2; end
            10'd2: begin rom_note = 20'd2; rom_dur = 5'd1; end
            default: ;
        endcase
    end

    // Expected outputs t cycles after the start edge (t=0 is the first LOAD).
    function automatic logic e_spk(input int t);
        return ((t >= 5) && (t <= 8)) || ((t >= 29) && (t <= 30)) || ((t >= 33) && (t <= 34));
    endfunction

    function automatic logic [NUM_W-1:0] e_num(input int t);
        if (t <= 8)  return 10'd0;
        if (t <= 25) return 10'd1;
        if (t <= 34) return 10'd2;
        return 10'd0;
    endfunction

    function automatic logic e_busy(input int t);
        return (t <= 34);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".number"},  32'(number),  32'd0);
        chk({tag, ".speaker"}, 32'(speaker), 32'd0);
        chk({tag, ".busy"},    32'(busy),    32'd0);
        chk({tag, ".done"},    32'(done),    32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        loop_en   = 1'b0;
        dur0_mode = 1'b0;
        #12;
        chk_idle("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle($sformatf("idle%0d", i));
        end

        // Full song without looping; extra start pulses while busy must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 36; t++) begin
            chk($sformatf("once.spk.t%0d", t),  32'(speaker), 32'(e_spk(t)));
            chk($sformatf("once.busy.t%0d", t), 32'(busy),    32'(e_busy(t)));
            chk($sformatf("once.done.t%0d", t), 32'(done),    32'(t == 35));
            if (t != 35)
                chk($sformatf("once.num.t%0d", t), 32'(number), 32'(e_num(t)));
            start = (t == 3) || (t == 12);
            tick();
        end
        start = 1'b0;
        chk_idle("after_once");

        // start and stop together: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("startstop0");
        tick();
        chk_idle("startstop1");

        // Looping playback, then stop in the middle of entry 1 on the second pass.
        loop_en = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 49; t++) begin
            chk($sformatf("loop.spk.t%0d", t),  32'(speaker), 32'(e_spk(t % 35)));
            chk($sformatf("loop.num.t%0d", t),  32'(number),  32'(e_num(t % 35)));
            chk($sformatf("loop.busy.t%0d", t), 32'(busy),    32'd1);
            chk($sformatf("loop.done.t%0d", t), 32'(done),    32'd0);
            if (t == 49) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        chk_idle("after_stop");
        tick();
        chk_idle("after_stop1");
        loop_en = 1'b0;

        // Duration 0 plays as a single eighth.
        dur0_mode = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 9; t++) begin
            chk($sformatf("dur0.num.t%0d", t),  32'(number), 32'(e_num(t)));
            chk($sformatf("dur0.busy.t%0d", t), 32'(busy),   32'd1);
            tick();
        end
        stop = 1'b1;
        tick();
        stop      = 1'b0;
        dur0_mode = 1'b0;
        chk_idle("dur0_stop");

        // Asynchronous reset mid-PLAY clears outputs before the next edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        chk("arst.pre.spk", 32'(speaker), 32'd1);
        chk("arst.pre.num", 32'(number),  32'd2);
        chk("arst.pre.busy", 32'(busy),   32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("arst.async");
        #2;
        rst_n = 1'b1;
        tick();
        chk_idle("arst.post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
